booth_dot_engine: RTL and testbench

Parametrised, pipelined signed dot-product engine, successor to the fixed 8-bit, four-lane Booth multiply/sum tree. Accepts LANES operand pairs per beat over a valid/ready stream and multiplies each pair with radix-4 Booth recoding. Accumulates products across a multi-beat vector delimited by first/last flags, and presents one result per vector on a backpressured output. Sits between the operand-fetch streamer and the result writeback of the matrix-multiply datapath.

---
 rtl/booth_dot_pkg.sv | 36 +++
 rtl/booth_pp_gen.sv | 45 ++++
 rtl/booth_dot_engine.sv | 164 ++++++++++++++++
 tb/tb_booth_dot_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_dot_pkg.sv
// booth_dot_pkg: shared types and helpers for the Booth dot-product engine.
//   booth_digit_e  : radix-4 Booth digit {0, +1, +2, -1, -2}
//   booth_encode() : maps a 3-bit multiplier window {a[2k+1], a[2k], a[2k-1]} to a digit
//   pp_count()     : partial products per lane (DATA_W/2)
//   prod_w()       : full product width (2*DATA_W)
package booth_dot_pkg;

   typedef enum logic [2:0] {
      BoothZero,
      BoothP1,
      BoothP2,
      BoothM1,
      BoothM2
   } booth_digit_e;

   function automatic int unsigned pp_count(input int unsigned data_w);
      return data_w / 2;
   endfunction

   function automatic int unsigned prod_w(input int unsigned data_w);
      return 2 * data_w;
   endfunction

   function automatic booth_digit_e booth_encode(input logic [2:0] win);
      booth_digit_e dig;
      unique case (win)
         3'b000, 3'b111: dig = BoothZero;
         3'b001, 3'b010: dig = BoothP1;
         3'b011:         dig = BoothP2;
         3'b100:         dig = BoothM2;
         default:        dig = BoothM1;  // 3'b101, 3'b110
      endcase
      return dig;
   endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: one lane of radix-4 Booth partial-product generation (combinational).
// Ports:
//   a  : DATA_W signed multiplier (recoded)
//   b  : DATA_W signed multiplicand
//   pp : PP_COUNT partial products, PROD_W bits each, already shifted by 2*index;
//        partial product k is pp[k*PROD_W +: PROD_W]
module booth_pp_gen
   import booth_dot_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0]                                 a,
   input  logic [DATA_W-1:0]                                 b,
   output logic [pp_count(DATA_W)*prod_w(DATA_W)-1:0]        pp
);

   localparam int unsigned PP_COUNT = pp_count(DATA_W);
   localparam int unsigned PROD_W   = prod_w(DATA_W);

   logic signed [PROD_W-1:0] b_ext;
   logic signed [PROD_W-1:0] mag;
   logic        [DATA_W:0]   a_ext;
   booth_digit_e             dig;

   always_comb begin
      // Widen before negating so -(-2^(DATA_W-1)) and its double are exact.
      b_ext = PROD_W'($signed(b));
      a_ext = {a, 1'b0};
      pp    = '0;
      mag   = '0;
      dig   = BoothZero;
      for (int unsigned k = 0; k < PP_COUNT; k++) begin
         dig = booth_encode(a_ext[2*k +: 3]);
         unique case (dig)
            BoothP1: mag = b_ext;
            BoothP2: mag = b_ext <<< 1;
            BoothM1: mag = -b_ext;
            BoothM2: mag = -(b_ext <<< 1);
            default: mag = '0;
         endcase
         pp[k*PROD_W +: PROD_W] = mag << (2*k);
      end
   end

endmodule

// File: rtl/booth_dot_engine.sv
// booth_dot_engine: pipelined signed dot-product engine with radix-4 Booth lanes.
// Pipeline: S1 Booth partial products -> S2 per-lane + cross-lane sum -> S3 accumulate.
// Ports:
//   clk, reset              : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready       : input beat handshake
//   in_first/in_last        : vector delimiters (ignored when in_valid=0)
//   in_a, in_b              : LANES packed signed operands, lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready     : result handshake
//   out_data                : ACC_W signed dot product of the vector
//   out_overflow            : accumulator overflowed during the vector
// Build option: define BOOTH_DOT_SAT_EN to saturate the accumulator and report a sticky
// overflow flag; otherwise the accumulator wraps and out_overflow is tied to 0.
module booth_dot_engine
   import booth_dot_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LANES  = 4,
   parameter int unsigned ACC_W  = 24
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_first,
   input  logic                      in_last,
   input  logic [LANES*DATA_W-1:0]   in_a,
   input  logic [LANES*DATA_W-1:0]   in_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ACC_W-1:0]          out_data,
   output logic                      out_overflow
);

   localparam int unsigned PP_COUNT = pp_count(DATA_W);
   localparam int unsigned PROD_W   = prod_w(DATA_W);
   localparam int unsigned PP_W     = PP_COUNT * PROD_W;

   logic stall;

   logic [PP_W-1:0] pp_comb  [LANES];
   logic [PP_W-1:0] s1_pp_q  [LANES];
   logic            s1_valid_q, s1_first_q, s1_last_q;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  lane_sum;
   logic signed [ACC_W-1:0]  s2_sum_q;
   logic                     s2_valid_q, s2_first_q, s2_last_q;

   logic signed [ACC_W-1:0]  acc_q, base, acc_sum, acc_next;
   logic        [ACC_W-1:0]  out_data_q;
   logic                     out_valid_q;

   // The whole pipeline freezes while a result waits for the consumer.
   assign stall     = out_valid_q & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      booth_pp_gen #(
         .DATA_W (DATA_W)
      ) u_pp_gen (
         .a  (in_a[l*DATA_W +: DATA_W]),
         .b  (in_b[l*DATA_W +: DATA_W]),
         .pp (pp_comb[l])
      );
   end

   always_comb begin
      lane_sum = '0;
      prod     = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         prod = '0;
         for (int unsigned k = 0; k < PP_COUNT; k++) begin
            prod = prod + s1_pp_q[l][k*PROD_W +: PROD_W];
         end
         lane_sum = lane_sum + ACC_W'(prod);
      end
   end

`ifdef BOOTH_DOT_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic add_ovf, sticky_q, sticky_next, out_overflow_q;
`endif

   always_comb begin
      base    = s2_first_q ? '0 : acc_q;
      acc_sum = base + s2_sum_q;
`ifdef BOOTH_DOT_SAT_EN
      // Signed overflow: operands agree in sign, result does not.
      add_ovf = (base[ACC_W-1] == s2_sum_q[ACC_W-1]) && (acc_sum[ACC_W-1] != base[ACC_W-1]);
      if (add_ovf) begin
         acc_next = base[ACC_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_next = acc_sum;
      end
      sticky_next = (s2_first_q ? 1'b0 : sticky_q) | add_ovf;
`else
      acc_next = acc_sum;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            s1_pp_q[l] <= '0;
         end
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s2_sum_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_first_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (!stall) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            s1_pp_q[l] <= pp_comb[l];
         end
         s1_valid_q  <= in_valid;
         s1_first_q  <= in_valid & in_first;
         s1_last_q   <= in_valid & in_last;
         s2_sum_q    <= lane_sum;
         s2_valid_q  <= s1_valid_q;
         s2_first_q  <= s1_first_q;
         s2_last_q   <= s1_last_q;
         // Not stalled implies any held result is being taken on this edge.
         out_valid_q <= s2_valid_q & s2_last_q;
         if (s2_valid_q) begin
            if (s2_last_q) begin
               out_data_q <= acc_next;
               acc_q      <= '0;
            end else begin
               acc_q      <= acc_next;
            end
         end
      end
   end

`ifdef BOOTH_DOT_SAT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sticky_q       <= 1'b0;
         out_overflow_q <= 1'b0;
      end else if (!stall && s2_valid_q) begin
         if (s2_last_q) begin
            out_overflow_q <= sticky_next;
            sticky_q       <= 1'b0;
         end else begin
            sticky_q       <= sticky_next;
         end
      end
   end

   assign out_overflow = out_overflow_q;
`else
   assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_booth_dot_engine.sv
// tb_booth_dot_engine: directed + randomized bench for booth_dot_engine.
// Main DUT: DATA_W=8, LANES=4, ACC_W=24. Second DUT with ACC_W=18 exercises overflow.
// Honours BOOTH_DOT_SAT_EN for the overflow expectations.
module tb_booth_dot_engine;

   localparam longint ACC_MAX = (64'sd1 <<< 23) - 1;
   localparam longint ACC_MIN = -(64'sd1 <<< 23);

   typedef struct {
      longint data;
      longint ovf;
   } res_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_first, in_last;
   logic [31:0] in_a, in_b;
   logic        out_valid, out_ready, out_overflow;
   logic [23:0] out_data;
   logic        ready_mode, ready_fixed, ready_rnd;

   logic        r_valid, r_in_ready, r_first, r_last, r_out_valid, r_out_ovf;
   logic        r_out_ready;
   logic [31:0] r_a, r_b;
   logic [17:0] r_out_data;

   int     passed = 0;
   int     total  = 0;
   res_t   got[$];
   res_t   exp_q[$];
   longint mdl_acc;
   longint mdl_sticky;

   always #5 clk = ~clk;

   assign out_ready   = ready_mode ? ready_rnd : ready_fixed;
   assign r_out_ready = 1'b1;

   booth_dot_engine #(
      .DATA_W (8),
      .LANES  (4),
      .ACC_W  (24)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_first     (in_first),
      .in_last      (in_last),
      .in_a         (in_a),
      .in_b         (in_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_overflow (out_overflow)
   );

   booth_dot_engine #(
      .DATA_W (8),
      .LANES  (4),
      .ACC_W  (18)
   ) u_dut18 (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (r_valid),
      .in_ready     (r_in_ready),
      .in_first     (r_first),
      .in_last      (r_last),
      .in_a         (r_a),
      .in_b         (r_b),
      .out_valid    (r_out_valid),
      .out_ready    (r_out_ready),
      .out_data     (r_out_data),
      .out_overflow (r_out_ovf)
   );

   always @(posedge clk) begin
      #1;
      ready_rnd = ($urandom_range(0, 2) != 0);
   end

   // A result is taken at the next rising edge when valid and ready are both high here.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         got.push_back('{data: longint'($signed(out_data)), ovf: longint'(out_overflow)});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 50000 cycles");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input longint obs, input longint expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   function automatic logic [31:0] pack4(input int v0, input int v1, input int v2, input int v3);
      return {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
   endfunction

   function automatic longint wrap24(input longint v);
      logic signed [23:0] t;
      t = v[23:0];
      return t;
   endfunction

   // Reference: dot product by plain multiplication, vector accumulation by the flag rules.
   task automatic model_beat(input logic first, input logic last,
                             input logic [31:0] a, input logic [31:0] b);
      longint ls, base, s, ov;
      ls = 0;
      for (int i = 0; i < 4; i++) begin
         ls += longint'($signed(a[i*8 +: 8])) * longint'($signed(b[i*8 +: 8]));
      end
      base = first ? 0 : mdl_acc;
      s    = base + ls;
      ov   = (s > ACC_MAX || s < ACC_MIN) ? 1 : 0;
`ifdef BOOTH_DOT_SAT_EN
      if (ov != 0) s = (s > 0) ? ACC_MAX : ACC_MIN;
      mdl_sticky = (first ? 0 : mdl_sticky) | ov;
`else
      s = wrap24(s);
      mdl_sticky = 0;
`endif
      if (last) begin
         exp_q.push_back('{data: s, ovf: mdl_sticky});
         mdl_acc    = 0;
         mdl_sticky = 0;
      end else begin
         mdl_acc = s;
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      r_valid  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset      = 1'b0;
      mdl_acc    = 0;
      mdl_sticky = 0;
      got.delete();
      exp_q.delete();
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the beat.
   task automatic send(input logic first, input logic last,
                       input logic [31:0] a, input logic [31:0] b);
      int  n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      in_valid = 1'b1;
      in_first = first;
      in_last  = last;
      in_a     = a;
      in_b     = b;
      while (!ok && n < 200) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      chk("beat_accepted", longint'(ok), 1);
      @(posedge clk);
      #1;
      if (ok) model_beat(first, last, a, b);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   // Idle cycles with junk flags, which must be ignored while in_valid=0.
   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         in_first = 1'($urandom_range(0, 1));
         in_last  = 1'($urandom_range(0, 1));
         in_a     = $urandom;
         @(posedge clk);
         #1;
      end
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_results(input string tag);
      int n;
      n = 0;
      ready_mode  = 1'b0;
      ready_fixed = 1'b1;
      while (got.size() < exp_q.size() && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (8) @(posedge clk);
      #1;
      chk({tag, "_count"}, longint'(got.size()), longint'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         chk({tag, "_data"}, got[i].data, exp_q[i].data);
         chk({tag, "_ovf"}, got[i].ovf, exp_q[i].ovf);
      end
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      int n;
      int len;
      logic f;
      in_valid    = 1'b0;
      in_first    = 1'b0;
      in_last     = 1'b0;
      in_a        = '0;
      in_b        = '0;
      r_valid     = 1'b0;
      r_first     = 1'b0;
      r_last      = 1'b0;
      r_a         = '0;
      r_b         = '0;
      ready_mode  = 1'b0;
      ready_fixed = 1'b1;
      mdl_acc     = 0;
      mdl_sticky  = 0;

      // Reset state
      do_reset();
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_out_ovf", longint'(out_overflow), 0);
      chk("rst_in_ready", longint'(in_ready), 1);

      // Single-beat vector 70; out_valid rises on the third edge counting the accepting one
      send(1'b1, 1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
      chk("lat_edge1", longint'(out_valid), 0);
      @(posedge clk);
      #1;
      chk("lat_edge2", longint'(out_valid), 0);
      @(posedge clk);
      #1;
      chk("lat_edge3", longint'(out_valid), 1);
      chk("lat_data", longint'($signed(out_data)), 70);
      chk("lat_ovf", longint'(out_overflow), 0);
      check_results("dot70");

      // Most-negative operand, back to back
      send(1'b1, 1'b1, 32'h8080_8080, 32'h8080_8080);
      send(1'b1, 1'b1, 32'h8080_8080, 32'h7f7f_7f7f);
      check_results("minneg");

      // Three-beat vector then a single-beat vector
      send(1'b1, 1'b0, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2));
      send(1'b0, 1'b0, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2));
      send(1'b0, 1'b1, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2));
      send(1'b1, 1'b1, pack4(-1, -1, -1, -1), pack4(3, 3, 3, 3));
      check_results("multibeat");

      // Backpressure: two vectors complete while out_ready=0
      ready_fixed = 1'b0;
      send(1'b1, 1'b1, $urandom, $urandom);
      send(1'b1, 1'b1, $urandom, $urandom);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_data", longint'($signed(out_data)), exp_q[0].data);
      repeat (4) @(posedge clk);
      #1;
      chk("bp_hold_valid", longint'(out_valid), 1);
      chk("bp_hold_data", longint'($signed(out_data)), exp_q[0].data);
      check_results("bp");

      // First in mid-vector restarts accumulation
      send(1'b1, 1'b0, pack4(10, 10, 10, 10), pack4(10, 10, 10, 10));
      send(1'b1, 1'b1, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
      check_results("restart");

      // Reset mid-vector discards the partial vector
      send(1'b1, 1'b0, pack4(10, 10, 10, 10), pack4(10, 10, 10, 10));
      do_reset();
      send(1'b1, 1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
      check_results("rst_mid");

      // Randomized vectors with gaps, occasional missing/extra first, random out_ready
      ready_mode = 1'b1;
      for (int v = 0; v < 40; v++) begin
         len = $urandom_range(1, 4);
         for (int j = 0; j < len; j++) begin
            if (j == 0) f = ($urandom_range(0, 7) != 0);
            else        f = ($urandom_range(0, 15) == 0);
            send(f, (j == len - 1), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end
      check_results("rand");

      // 18-bit accumulator overflow: two beats of 65536 each
      r_valid = 1'b1;
      r_first = 1'b1;
      r_last  = 1'b0;
      r_a     = 32'h8080_8080;
      r_b     = 32'h8080_8080;
      @(posedge clk);
      #1;
      r_first = 1'b0;
      r_last  = 1'b1;
      @(posedge clk);
      #1;
      r_valid = 1'b0;
      r_last  = 1'b0;
      n = 0;
      while (!r_out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("ovf_valid", longint'(r_out_valid), 1);
`ifdef BOOTH_DOT_SAT_EN
      chk("ovf_data", longint'($signed(r_out_data)), 131071);
      chk("ovf_flag", longint'(r_out_ovf), 1);
`else
      chk("ovf_data", longint'($signed(r_out_data)), -131072);
      chk("ovf_flag", longint'(r_out_ovf), 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
